clock_period_meter: RTL and testbench

CLOCK_PERIOD_METER -- requirements
Module: clock_period_meter

---
 rtl/clock_period_meter.sv | 113 +++++++++++
 tb/tb_clock_period_meter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_period_meter.sv
// clock_period_meter
//   Measures the rise-to-rise period and rise-to-fall high time of a slow,
//   asynchronous clock g_in in units of clock_in cycles. It flags lock when
//   the period is within TOLERANCE of EXPECTED, and it abandons a measurement
//   after TIMEOUT cycles without a rising edge.
//
// Ports
//   clock_in   in   1   system clock, all logic on its rising edge
//   reset_n    in   1   synchronous reset, active-low
//   g_in       in   1   measured slow clock, asynchronous to clock_in
//   period     out  28  last rise-to-rise interval (clock_in cycles)
//   high_time  out  28  last rise-to-fall interval (clock_in cycles)
//   valid      out  1   one-cycle pulse when period is updated
//   locked     out  1   last period within TOLERANCE of EXPECTED
//   timeout    out  1   one-cycle pulse when TIMEOUT expires
module clock_period_meter #(
    parameter logic [27:0] EXPECTED  = 28'd200000,
    parameter logic [27:0] TOLERANCE = 28'd16,
    parameter logic [27:0] TIMEOUT   = 28'd800000
) (
    input  logic        clock_in,
    input  logic        reset_n,
    input  logic        g_in,
    output logic [27:0] period,
    output logic [27:0] high_time,
    output logic        valid,
    output logic        locked,
    output logic        timeout
);

    localparam int DATA_W = 28;
    localparam logic [DATA_W-1:0] CNT_LIMIT = TIMEOUT - 28'd1;

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t            state;
    logic              g_sync_p0;
    logic              g_sync_p1;
    logic              g_prev_p2;
    logic [DATA_W-1:0] cnt;
    logic [DATA_W-1:0] cnt_inc;
    logic              rise;
    logic              fall;

    // Distance between two unsigned values, always larger minus smaller so
    // the result never wraps.
    function automatic logic [DATA_W-1:0] abs_diff(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic within_tol(input logic [DATA_W-1:0] p);
        return abs_diff(p, EXPECTED) <= TOLERANCE;
    endfunction

    // cnt is capped at TIMEOUT-1, so cnt+1 always fits in DATA_W bits.
    assign cnt_inc = cnt + 28'd1;
    assign rise    = g_sync_p1 & ~g_prev_p2;
    assign fall    = ~g_sync_p1 & g_prev_p2;

    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            state     <= IDLE;
            g_sync_p0 <= 1'b0;
            g_sync_p1 <= 1'b0;
            g_prev_p2 <= 1'b0;
            cnt       <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            locked    <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            // p0/p1: two-flop synchronizer for the asynchronous g_in
            g_sync_p0 <= g_in;
            g_sync_p1 <= g_sync_p0;
            // p2: previous synchronized level, for edge detection
            g_prev_p2 <= g_sync_p1;

            valid   <= 1'b0;
            timeout <= 1'b0;

            // FSM / measurement stage, fed by the p1/p2 edge detect
            if (state == IDLE) begin
                // The first rise only arms the counter; no outputs change.
                if (rise) begin
                    state <= MEASURE;
                    cnt   <= '0;
                end
            end else begin
                if (rise) begin
                    // A rise wins over a coincident timeout.
                    period <= cnt_inc;
                    locked <= within_tol(cnt_inc);
                    valid  <= 1'b1;
                    cnt    <= '0;
                end else if (cnt == CNT_LIMIT) begin
                    // A coincident fall is dropped; high_time holds.
                    timeout <= 1'b1;
                    locked  <= 1'b0;
                    cnt     <= '0;
                    state   <= IDLE;
                end else begin
                    cnt <= cnt_inc;
                    if (fall) begin
                        high_time <= cnt_inc;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_clock_period_meter.sv
module tb_clock_period_meter;

    localparam int EXP = 200;
    localparam int TOL = 16;
    localparam int TMO = 800;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        g_in;
    logic        g2;
    logic [27:0] period, high_time, period2, high_time2;
    logic        valid, locked, timeout, valid2, locked2, timeout2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rise = 0;

    always #5 clk = ~clk;

    clock_period_meter #(
        .EXPECTED (28'd200),
        .TOLERANCE(28'd16),
        .TIMEOUT  (28'd800)
    ) dut (
        .clock_in (clk),
        .reset_n  (reset_n),
        .g_in     (g_in),
        .period   (period),
        .high_time(high_time),
        .valid    (valid),
        .locked   (locked),
        .timeout  (timeout)
    );

    clock_period_meter #(
        .EXPECTED (28'd10),
        .TOLERANCE(28'd0),
        .TIMEOUT  (28'd10)
    ) dut2 (
        .clock_in (clk),
        .reset_n  (reset_n),
        .g_in     (g2),
        .period   (period2),
        .high_time(high_time2),
        .valid    (valid2),
        .locked   (locked2),
        .timeout  (timeout2)
    );

    // Reference model: works on timestamps of g_in edges. An edge applied
    // after clock edge c becomes visible to the measurement at edge c+3.
    typedef struct {
        int e;
        bit rise;
    } det_t;

    det_t pend[$];
    bit   m_meas = 0;
    int   m_r0 = 0;
    int   m_period = 0;
    int   m_high = 0;
    bit   m_locked = 0;
    bit   m_valid = 0;
    bit   m_timeout = 0;
    logic rst_applied;

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Wait one clock edge, evaluate the model for that edge, compare, then
    // apply the next g_in / reset_n values.
    task automatic step(input logic g, input logic rn);
        bit r_e;
        bit f_e;
        int d;
        @(posedge clk);
        cyc++;
        #1;
        r_e = 0;
        f_e = 0;
        m_valid = 0;
        m_timeout = 0;
        if (!rst_applied) begin
            pend.delete();
            m_meas = 0;
            m_period = 0;
            m_high = 0;
            m_locked = 0;
        end else begin
            if (pend.size() > 0 && pend[0].e == cyc) begin
                r_e = pend[0].rise;
                f_e = !pend[0].rise;
                void'(pend.pop_front());
            end
            if (!m_meas) begin
                if (r_e) begin
                    m_meas = 1;
                    m_r0 = cyc;
                end
            end else if (r_e) begin
                m_period = cyc - m_r0;
                d = m_period - EXP;
                if (d < 0) d = -d;
                m_locked = (d <= TOL);
                m_valid = 1;
                m_r0 = cyc;
            end else if (cyc - m_r0 == TMO) begin
                m_timeout = 1;
                m_locked = 0;
                m_meas = 0;
            end else if (f_e) begin
                m_high = cyc - m_r0;
            end
        end
        checks++;
        if (valid !== m_valid || timeout !== m_timeout || locked !== m_locked ||
            period !== 28'(m_period) || high_time !== 28'(m_high)) begin
            errors++;
            $display("FAIL model cyc=%0d got v=%b t=%b l=%b p=%0d h=%0d expected v=%b t=%b l=%b p=%0d h=%0d",
                     cyc, valid, timeout, locked, period, high_time,
                     m_valid, m_timeout, m_locked, m_period, m_high);
        end
        if (rn && (g !== g_in)) pend.push_back('{e: cyc + 3, rise: g});
        g_in = g;
        reset_n = rn;
        rst_applied = rn;
    endtask

    // One g_in period starting with a rise; the rise's result (measuring the
    // previous period) is checked on the third edge after it.
    task automatic apply_row(input int hi, input int lo, input bit ev, input int ep,
                             input int eh, input bit el, input string nm);
        for (int j = 0; j < hi + lo; j++) begin
            step(j < hi, 1'b1);
            if (j == 0) last_rise = cyc;
            if (j == 3) begin
                chk({nm, "_valid"}, valid, ev);
                if (ev) begin
                    chk({nm, "_period"}, period, ep);
                    chk({nm, "_high"}, high_time, eh);
                    chk({nm, "_locked"}, locked, el);
                end
            end
        end
    endtask

    typedef struct {
        int hi;
        int lo;
        bit ev;
        int ep;
        int eh;
        bit el;
    } row_t;

    row_t tbl[8];
    int   n;
    bit   seen;
    int   v2_cnt;
    int   t2_cnt;
    int   hi_r;
    int   per_r;

    initial begin
        #50_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{100, 100, 0, 0,   0,   0};
        tbl[1] = '{100, 100, 1, 200, 100, 1};
        tbl[2] = '{110, 110, 1, 200, 100, 1};
        tbl[3] = '{92,  92,  1, 220, 110, 0};
        tbl[4] = '{100, 116, 1, 184, 92,  1};
        tbl[5] = '{50,  167, 1, 216, 100, 1};
        tbl[6] = '{1,   199, 1, 217, 50,  0};
        tbl[7] = '{100, 100, 1, 200, 1,   1};

        reset_n = 1'b0;
        rst_applied = 1'b0;
        g_in = 1'b0;
        g2 = 1'b0;

        // Reset state
        step(1'b0, 1'b0);
        chk("rst_period", period, 0);
        chk("rst_high", high_time, 0);
        chk("rst_valid", valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_timeout", timeout, 0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);

        // Nominal, tolerance boundaries
        for (int i = 0; i < 8; i++)
            apply_row(tbl[i].hi, tbl[i].lo, tbl[i].ev, tbl[i].ep, tbl[i].eh, tbl[i].el,
                      $sformatf("row%0d", i));

        // Timeout after lock
        n = 0;
        seen = 0;
        while (!seen && n < 2000) begin
            step(1'b0, 1'b1);
            n++;
            if (timeout) seen = 1;
        end
        chk("timeout_seen", seen, 1);
        chk("timeout_latency", cyc - (last_rise + 3), TMO);
        chk("timeout_locked", locked, 0);
        chk("timeout_period_hold", period, 200);
        chk("timeout_valid", valid, 0);
        apply_row(100, 100, 0, 0, 0, 0, "post_timeout_rise");
        apply_row(100, 100, 1, 200, 100, 1, "post_timeout_second");

        // Reset in the middle of a measurement
        for (int j = 0; j < 49; j++) step(j < 40, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("midrst_period", period, 0);
        chk("midrst_high", high_time, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_locked", locked, 0);
        chk("midrst_timeout", timeout, 0);
        for (int j = 0; j < 140; j++) step(1'b0, 1'b1);
        apply_row(100, 100, 0, 0, 0, 0, "midrst_first_rise");
        apply_row(100, 100, 1, 200, 100, 1, "midrst_second_rise");

        // Fastest legal g_in: 2 high / 2 low
        apply_row(2, 2, 1, 200, 100, 1, "fast_entry");
        for (int i = 0; i < 10; i++) apply_row(2, 2, 1, 4, 2, 0, "fast");
        for (int j = 0; j < 900; j++) step(1'b0, 1'b1);

        // Rise coinciding with cnt == TIMEOUT-1 on the TIMEOUT=10 instance
        v2_cnt = 0;
        t2_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            step(1'b0, 1'b1);
            if (valid2) begin
                v2_cnt++;
                chk("t10_period", period2, 10);
                chk("t10_high", high_time2, 5);
            end
            if (timeout2) t2_cnt++;
            g2 = ((k % 10) < 5);
        end
        chk("t10_valid_count", v2_cnt, 5);
        chk("t10_timeout_count", t2_cnt, 0);
        g2 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b1);
            if (timeout2) t2_cnt++;
        end
        chk("t10_final_timeout", t2_cnt, 1);

        // Randomized periods around nominal with occasional long gaps
        for (int i = 0; i < 60; i++) begin
            hi_r = $urandom_range(1, 120);
            per_r = $urandom_range(170, 230);
            if ($urandom_range(0, 7) == 0) per_r += TMO;
            for (int j = 0; j < per_r; j++) step(j < hi_r, 1'b1);
        end
        for (int j = 0; j < 10; j++) step(1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
